// File: rtl/tone_meter.sv
// tone_meter: measures a tone in a signed 16-bit sample stream.
// Over each window of 2^GATE_LOG2 strobed samples it counts rising zero
// crossings (with a hysteresis band) and tracks the peak absolute amplitude,
// then publishes both with a one-cycle valid pulse.
module tone_meter #(
    parameter int GATE_LOG2 = 16,
    parameter int HYST      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [15:0]      din,
    input  logic                    load,
    output logic [GATE_LOG2:0]      cnt,
    output logic [14:0]             peak,
    output logic                    valid
);

    // Level tracker: UNK until the first excursion outside the band.
    typedef enum logic [1:0] {
        LVL_UNK = 2'd0,
        LVL_NEG = 2'd1,
        LVL_POS = 2'd2
    } level_t;

    localparam logic signed [15:0] HYST_HI = 16'(HYST);
    localparam logic signed [15:0] HYST_LO = 16'(-HYST);

    // |x| in 15 bits; the single unrepresentable value -32768 clips to 32767.
    function automatic logic [14:0] sat_abs(input logic signed [15:0] x);
        logic signed [15:0] neg;
        neg = -x;
        if (x == 16'sh8000) begin
            return 15'h7fff;
        end
        if (x[15]) begin
            return neg[14:0];
        end
        return x[14:0];
    endfunction

    function automatic logic [14:0] max15(input logic [14:0] a, input logic [14:0] b);
        return (a > b) ? a : b;
    endfunction

    level_t                 level_q;
    level_t                 level_d;
    logic                   rise_p0;
    logic [14:0]            mag_p0;
    logic                   last_p0;
    logic [GATE_LOG2:0]     cross_sum_p0;
    logic [14:0]            peak_max_p0;

    logic [GATE_LOG2-1:0]   sample_cnt;
    logic [GATE_LOG2:0]     cross_acc;
    logic [14:0]            peak_acc;

    // Next level and crossing event; only a NEG->POS move counts as a rise.
    always_comb begin
        level_d = level_q;
        rise_p0 = 1'b0;
        if (load) begin
            case (level_q)
                LVL_UNK: begin
                    if (din > HYST_HI) begin
                        level_d = LVL_POS;
                    end else if (din < HYST_LO) begin
                        level_d = LVL_NEG;
                    end
                end
                LVL_NEG: begin
                    if (din > HYST_HI) begin
                        level_d = LVL_POS;
                        rise_p0 = 1'b1;
                    end
                end
                LVL_POS: begin
                    if (din < HYST_LO) begin
                        level_d = LVL_NEG;
                    end
                end
                default: level_d = LVL_UNK;
            endcase
        end
    end

    // Level state register; persists across window boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= LVL_UNK;
        end else begin
            level_q <= level_d;
        end
    end

    // Per-sample terms folded into the closing-window results.
    always_comb begin
        mag_p0       = sat_abs(din);
        last_p0      = load && (sample_cnt == '1);
        cross_sum_p0 = cross_acc + (GATE_LOG2 + 1)'(rise_p0);
        peak_max_p0  = max15(peak_acc, mag_p0);
    end

    // ---- stage boundary: window accumulators and published results ----
    // Accumulate per load; on the last sample of a window publish and clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= '0;
            cross_acc  <= '0;
            peak_acc   <= '0;
            cnt        <= '0;
            peak       <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= last_p0;
            if (load) begin
                sample_cnt <= sample_cnt + 1'b1;
                if (last_p0) begin
                    cnt       <= cross_sum_p0;
                    peak      <= peak_max_p0;
                    cross_acc <= '0;
                    peak_acc  <= '0;
                end else begin
                    cross_acc <= cross_sum_p0;
                    peak_acc  <= peak_max_p0;
                end
            end
        end
    end

endmodule
